fetch_queue: RTL and testbench
==============================

# fetch_queue

Parametrised instruction-fetch front end for the pipelined core. It owns the program counter and issues one request per cycle to a synchronous-read instruction memory. Returned instructions are buffered in a DEPTH-entry prefetch FIFO and presented to decode through a valid/ready handshake. Branch redirects from EX flush the FIFO and squash any in-flight fetch in one cycle.

## Interface
- ADDR_W, 16, PC and instruction-memory address width
- INSTR_W, 16, instruction width
- DEPTH, 4, prefetch FIFO entries; power of two, ≥2
- NOP_INSTR, {INSTR_W{1'b0}}, value driven on id_instruction when id_valid=0

Ports:
- clk  in  1  clock
- pc_reset  in  1  reset, asynchronous, active-high
- imem_req  out  1  fetch issued this cycle
- imem_addr  out  ADDR_W  fetch address; meaningful when imem_req=1
- imem_data  in  INSTR_W  instruction for the previous cycle's request (1-cycle synchronous read)
- redirect  in  1  taken branch/jump from EX
- redirect_addr  in  ADDR_W  branch target
- id_ready  in  1  decode accepts head entry (low = stall)
- id_valid  out  1  head entry valid
- id_instruction  out  INSTR_W  head instruction, NOP_INSTR when empty
- id_pc_plus_1  out  ADDR_W  address of head instruction + 1
- count  out  $clog2(DEPTH+1)  FIFO occupancy

## Operation
- State: fetch_pc (ADDR_W), inflight (1 bit), inflight_pc (ADDR_W), FIFO of DEPTH × {ADDR_W+INSTR_W}, read/write pointers, count.
- Reset values: fetch_pc=0, inflight=0, count=0, pointers=0; outputs id_valid=0, id_instruction=NOP_INSTR, id_pc_plus_1=0, count=0.
- pop = id_valid & id_ready & ~redirect.
- Credit: imem_req = (count + inflight − pop) < DEPTH. FIFO can never overflow; a push into a full FIFO is impossible by construction.
- imem_addr = redirect ? redirect_addr : fetch_pc.
- On issue: inflight_pc ← imem_addr; fetch_pc ← imem_addr + 1 (mod 2^ADDR_W). No issue → fetch_pc holds (redirect still loads fetch_pc ← redirect_addr).
- inflight ← imem_req.
- Push: when inflight=1 and redirect=0, write {inflight_pc+1 mod 2^ADDR_W, imem_data} at write pointer.
- Redirect (priority over push and pop): count ← 0, pointers ← 0, returning data discarded, pop suppressed. The same cycle issues the request at redirect_addr; it is not squashed.
- Simultaneous push and pop: count unchanged, both pointers advance. Pointers wrap modulo DEPTH.
- id_instruction/id_pc_plus_1 read the head entry; they are forced to NOP_INSTR/0 when count=0.
- count output equals the internal occupancy.

## Timing
- Fetch-to-decode latency: request in cycle N → data in N+1 → pushed at end of N+1 → id_valid in N+2.
- Out of reset, imem_req=1 with imem_addr=0 in the first cycle; id_valid=1 with the instruction from address 0 two cycles later.
- Steady state with id_ready=1: one instruction per cycle for any DEPTH≥2.
- Redirect in cycle R: id_valid=0 in R+1, target instruction valid in R+2. No instruction fetched before R is ever presented after R.
- Stall (id_ready=0): head is held stable. The FIFO fills to DEPTH, then imem_req=0 until a pop. On the pop cycle imem_req may be 1.
- pc_reset asserted mid-operation: all state clears immediately, and any in-flight data is ignored after release.
- Address wrap: fetch at 0xFFFF (ADDR_W=16) yields id_pc_plus_1=0x0000, and the next fetch is address 0x0000.

## Test plan
- Reset release, memory returns instr=addr+0x1000, id_ready=1 → id_valid from cycle 2; instructions 0x1000, 0x1001, … back-to-back; id_pc_plus_1 = 1, 2, …
- id_ready=0 for 10 cycles after startup → count saturates at 4, imem_req=0 while full, head stays 0x1000. Releasing id_ready yields 0x1000..0x1003 and then the stream continues without a gap or duplicate.
- Redirect to 0x0040 with count=3 and inflight=1 → next cycle id_valid=0 and count=0; two cycles later head=0x1040, id_pc_plus_1=0x0041.
- Redirect coinciding with id_ready=1 while full → the popped entry is not counted, count=0, and the head after the flush is the target instruction.
- Redirect to 0xFFFE → presented pc_plus_1 sequence is 0xFFFF, 0x0000, 0x0001; fetch addresses wrap to 0x0000.
- pc_reset pulsed mid-stream while inflight=1 → outputs go to NOP_INSTR, id_valid=0, count=0 immediately; after release, fetch restarts at address 0 and no stale instruction appears.

Source files
------------

// File: rtl/fetch_queue_if.sv
// fetch_queue_if
//   Bundles the fetch front end's instruction-memory port, the EX redirect
//   and the decode handshake. The master modport is the fetch_queue side;
//   the slave modport is the memory/EX/decode environment.
//   imem_req/imem_addr   : fetch issued this cycle and its address
//   imem_data            : instruction for the previous cycle's request
//   redirect/_addr       : taken branch/jump from EX and its target
//   id_ready             : decode accepts the head entry
//   id_valid/instruction : head entry and its instruction (NOP when empty)
//   id_pc_plus_1         : address of the head instruction + 1
//   count                : prefetch FIFO occupancy
interface fetch_queue_if #(
    parameter int ADDR_W  = 16,
    parameter int INSTR_W = 16,
    parameter int DEPTH   = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_data;
    logic               redirect;
    logic [ADDR_W-1:0]  redirect_addr;
    logic               id_ready;
    logic               id_valid;
    logic [INSTR_W-1:0] id_instruction;
    logic [ADDR_W-1:0]  id_pc_plus_1;
    logic [CNT_W-1:0]   count;

    modport master (
        output imem_req, imem_addr, id_valid, id_instruction, id_pc_plus_1, count,
        input  imem_data, redirect, redirect_addr, id_ready
    );

    modport slave (
        input  imem_req, imem_addr, id_valid, id_instruction, id_pc_plus_1, count,
        output imem_data, redirect, redirect_addr, id_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue
//   Instruction-fetch front end. Owns the PC, issues at most one request per
//   cycle to a 1-cycle synchronous-read instruction memory, buffers returned
//   instructions in a DEPTH-entry FIFO and presents them to decode with a
//   valid/ready handshake. A redirect flushes the FIFO, drops the returning
//   fetch and issues the target fetch in the same cycle.
//   clk, pc_reset (async, active-high) and the fetch_queue_if master modport.
module fetch_queue #(
    parameter int                 ADDR_W    = 16,
    parameter int                 INSTR_W   = 16,
    parameter int                 DEPTH     = 4,
    parameter logic [INSTR_W-1:0] NOP_INSTR = '0
) (
    input  logic          clk,
    input  logic          pc_reset,
    fetch_queue_if.master fq
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

    typedef struct packed {
        logic [ADDR_W-1:0]  pc_plus_1;
        logic [INSTR_W-1:0] instr;
    } fq_entry_t;

    fq_entry_t          fifo [DEPTH];
    logic [ADDR_W-1:0]  fetch_pc;
    logic [ADDR_W-1:0]  inflight_pc;
    logic               inflight;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   occ;

    logic               head_valid;
    logic               pop;
    logic               push;
    logic               issue;
    logic [CNT_W:0]     pending;
    logic [ADDR_W-1:0]  req_addr;

    assign head_valid = (occ != '0);
    assign req_addr   = fq.redirect ? fq.redirect_addr : fetch_pc;
    assign pop        = head_valid & fq.id_ready & ~fq.redirect;
    assign push       = inflight & ~fq.redirect;

    // Entries held plus the one still coming back, minus the one leaving now.
    // Keeping this below DEPTH reserves a slot for every outstanding fetch,
    // so a push can never find the FIFO full.
    assign pending = {1'b0, occ} + {{CNT_W{1'b0}}, inflight} - {{CNT_W{1'b0}}, pop};

    // A redirect empties the FIFO and discards the returning fetch, so the
    // effective occupancy is zero and the target fetch always has room.
    assign issue = fq.redirect | (pending < DEPTH_C);

    always_ff @(posedge clk or posedge pc_reset) begin
        if (pc_reset) begin
            fetch_pc    <= '0;
            inflight_pc <= '0;
            inflight    <= 1'b0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            occ         <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_pc <= req_addr;
                fetch_pc    <= req_addr + ADDR_W'(1);
            end
            if (fq.redirect) begin
                occ    <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
                case ({push, pop})
                    2'b10:   occ <= occ + CNT_W'(1);
                    2'b01:   occ <= occ - CNT_W'(1);
                    default: occ <= occ;
                endcase
            end
        end
    end

    // Storage needs no reset: the outputs are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo[wr_ptr] <= '{pc_plus_1: inflight_pc + ADDR_W'(1), instr: fq.imem_data};
        end
    end

    assign fq.imem_req       = issue;
    assign fq.imem_addr      = req_addr;
    assign fq.id_valid       = head_valid;
    assign fq.id_instruction = head_valid ? fifo[rd_ptr].instr : NOP_INSTR;
    assign fq.id_pc_plus_1   = head_valid ? fifo[rd_ptr].pc_plus_1 : '0;
    assign fq.count          = occ;
endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
    logic clk = 1'b0;
    logic pc_reset;
    int   vectors = 0;
    int   miscompares = 0;
    logic [15:0] exp_q [$];

    always #5 clk = ~clk;

    fetch_queue_if #(.ADDR_W(16), .INSTR_W(16), .DEPTH(4)) bus ();

    fetch_queue #(.ADDR_W(16), .INSTR_W(16), .DEPTH(4), .NOP_INSTR(16'h0000)) dut (
        .clk      (clk),
        .pc_reset (pc_reset),
        .fq       (bus)
    );

    // Instruction memory: 1-cycle synchronous read, instr = addr + 0x1000.
    always @(posedge clk) begin
        if (bus.imem_req) bus.imem_data <= bus.imem_addr + 16'h1000;
    end

    // Expected presented stream restarts at t after reset release or redirect.
    task automatic sb_restart(input logic [15:0] t);
        exp_q.delete();
        for (int i = 0; i < 64; i++) exp_q.push_back(t + 16'(i));
    endtask

    // Checks every fetch address against the sequential/redirect rule and
    // every accepted instruction against the scoreboard.
    task automatic monitor();
        logic [15:0] exp_fetch;
        logic [15:0] a;
        exp_fetch = 16'h0;
        forever begin
            @(negedge clk);
            if (pc_reset) begin
                exp_fetch = 16'h0;
            end else begin
                if (bus.imem_req) begin
                    a = bus.redirect ? bus.redirect_addr : exp_fetch;
                    vectors++;
                    if (bus.imem_addr !== a) begin
                        miscompares++;
                        $display("FAIL fetch_addr: got %h expected %h", bus.imem_addr, a);
                    end
                    exp_fetch = a + 16'h1;
                end else if (bus.redirect) begin
                    exp_fetch = bus.redirect_addr;
                end
                if (bus.id_valid && bus.id_ready && !bus.redirect) begin
                    vectors++;
                    if (exp_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL sb_underflow: got instr %h expected none", bus.id_instruction);
                    end else begin
                        a = exp_q.pop_front();
                        if (bus.id_instruction !== a + 16'h1000 || bus.id_pc_plus_1 !== a + 16'h1) begin
                            miscompares++;
                            $display("FAIL sb_pop: got instr %h pc1 %h expected instr %h pc1 %h",
                                     bus.id_instruction, bus.id_pc_plus_1, a + 16'h1000, a + 16'h1);
                        end
                    end
                end
            end
        end
    endtask

    task automatic apply_reset(input logic rdy);
        @(posedge clk); #1;
        pc_reset = 1'b1; bus.redirect = 1'b0; bus.id_ready = rdy;
        repeat (2) @(posedge clk);
        #1;
        pc_reset = 1'b0;
        sb_restart(16'h0);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (bus.count !== 3'd0 || bus.id_valid !== 1'b0) begin
            miscompares++; $display("FAIL reset_state: got count %0d valid %b expected 0 0", bus.count, bus.id_valid);
        end
        vectors++;
        if (bus.id_instruction !== 16'h0 || bus.id_pc_plus_1 !== 16'h0) begin
            miscompares++; $display("FAIL reset_outputs: got %h %h expected 0000 0000", bus.id_instruction, bus.id_pc_plus_1);
        end
        @(posedge clk); #1;
        pc_reset = 1'b0;
        sb_restart(16'h0);
        @(negedge clk);
        vectors++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0 || bus.id_valid !== 1'b0) begin
            miscompares++; $display("FAIL first_fetch: got req %b addr %h valid %b expected 1 0000 0", bus.imem_req, bus.imem_addr, bus.id_valid);
        end
        @(negedge clk);
        vectors++;
        if (bus.id_valid !== 1'b0) begin
            miscompares++; $display("FAIL latency_c1: got valid %b expected 0", bus.id_valid);
        end
        @(negedge clk);
        vectors++;
        if (bus.id_valid !== 1'b1 || bus.id_instruction !== 16'h1000 || bus.id_pc_plus_1 !== 16'h1) begin
            miscompares++; $display("FAIL latency_c2: got valid %b instr %h pc1 %h expected 1 1000 0001", bus.id_valid, bus.id_instruction, bus.id_pc_plus_1);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            vectors++;
            if (bus.id_valid !== 1'b1 || bus.count !== 3'd1) begin
                miscompares++; $display("FAIL stream[%0d]: got valid %b count %0d expected 1 1", i, bus.id_valid, bus.count);
            end
        end
    endtask

    task automatic test_stall();
        apply_reset(1'b0);
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (n >= 2) begin
                vectors++;
                if (bus.id_valid !== 1'b1 || bus.id_instruction !== 16'h1000) begin
                    miscompares++; $display("FAIL stall_head[%0d]: got valid %b instr %h expected 1 1000", n, bus.id_valid, bus.id_instruction);
                end
            end
            if (n >= 5) begin
                vectors++;
                if (bus.count !== 3'd4 || bus.imem_req !== 1'b0) begin
                    miscompares++; $display("FAIL stall_full[%0d]: got count %0d req %b expected 4 0", n, bus.count, bus.imem_req);
                end
            end
        end
        @(posedge clk); #1;
        bus.id_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus.imem_req !== 1'b1) begin
            miscompares++; $display("FAIL stall_release_req: got %b expected 1", bus.imem_req);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            vectors++;
            if (bus.id_valid !== 1'b1) begin
                miscompares++; $display("FAIL stall_drain[%0d]: got valid %b expected 1", i, bus.id_valid);
            end
        end
    endtask

    task automatic test_redirect();
        apply_reset(1'b0);
        repeat (4) @(posedge clk);
        #1;
        bus.redirect = 1'b1; bus.redirect_addr = 16'h0040; bus.id_ready = 1'b1;
        sb_restart(16'h0040);
        @(negedge clk);
        vectors++;
        if (bus.count !== 3'd3 || bus.imem_req !== 1'b1) begin
            miscompares++; $display("FAIL redir_issue: got count %0d req %b expected 3 1", bus.count, bus.imem_req);
        end
        @(posedge clk); #1;
        bus.redirect = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus.id_valid !== 1'b0 || bus.count !== 3'd0 || bus.id_instruction !== 16'h0) begin
            miscompares++; $display("FAIL redir_flush: got valid %b count %0d instr %h expected 0 0 0000", bus.id_valid, bus.count, bus.id_instruction);
        end
        @(negedge clk);
        vectors++;
        if (bus.id_valid !== 1'b1 || bus.id_instruction !== 16'h1040 || bus.id_pc_plus_1 !== 16'h0041) begin
            miscompares++; $display("FAIL redir_target: got valid %b instr %h pc1 %h expected 1 1040 0041", bus.id_valid, bus.id_instruction, bus.id_pc_plus_1);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_redirect_full();
        apply_reset(1'b0);
        repeat (6) @(posedge clk);
        #1;
        bus.redirect = 1'b1; bus.redirect_addr = 16'h0200; bus.id_ready = 1'b1;
        sb_restart(16'h0200);
        @(negedge clk);
        vectors++;
        if (bus.count !== 3'd4 || bus.imem_req !== 1'b1) begin
            miscompares++; $display("FAIL full_redir_issue: got count %0d req %b expected 4 1", bus.count, bus.imem_req);
        end
        @(posedge clk); #1;
        bus.redirect = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus.id_valid !== 1'b0 || bus.count !== 3'd0) begin
            miscompares++; $display("FAIL full_redir_flush: got valid %b count %0d expected 0 0", bus.id_valid, bus.count);
        end
        @(negedge clk);
        vectors++;
        if (bus.id_instruction !== 16'h1200 || bus.id_pc_plus_1 !== 16'h0201) begin
            miscompares++; $display("FAIL full_redir_head: got instr %h pc1 %h expected 1200 0201", bus.id_instruction, bus.id_pc_plus_1);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_wrap();
        logic [15:0] exp_pc1 [3];
        logic [15:0] exp_ins [3];
        exp_pc1 = '{16'hFFFF, 16'h0000, 16'h0001};
        exp_ins = '{16'h0FFE, 16'h0FFF, 16'h1000};
        @(posedge clk); #1;
        bus.redirect = 1'b1; bus.redirect_addr = 16'hFFFE;
        sb_restart(16'hFFFE);
        @(posedge clk); #1;
        bus.redirect = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus.imem_addr !== 16'hFFFF) begin
            miscompares++; $display("FAIL wrap_fetch1: got %h expected ffff", bus.imem_addr);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 0) begin
                vectors++;
                if (bus.imem_addr !== 16'h0000) begin
                    miscompares++; $display("FAIL wrap_fetch2: got %h expected 0000", bus.imem_addr);
                end
            end
            vectors++;
            if (bus.id_pc_plus_1 !== exp_pc1[i] || bus.id_instruction !== exp_ins[i]) begin
                miscompares++; $display("FAIL wrap_seq[%0d]: got pc1 %h instr %h expected %h %h", i, bus.id_pc_plus_1, bus.id_instruction, exp_pc1[i], exp_ins[i]);
            end
        end
    endtask

    task automatic test_reset_midstream();
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        pc_reset = 1'b1;
        #1;
        vectors++;
        if (bus.id_valid !== 1'b0 || bus.count !== 3'd0 || bus.id_instruction !== 16'h0 || bus.id_pc_plus_1 !== 16'h0) begin
            miscompares++; $display("FAIL midreset_clear: got valid %b count %0d instr %h pc1 %h expected 0 0 0000 0000",
                                    bus.id_valid, bus.count, bus.id_instruction, bus.id_pc_plus_1);
        end
        @(posedge clk); #1;
        pc_reset = 1'b0;
        sb_restart(16'h0);
        @(negedge clk);
        vectors++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0 || bus.id_valid !== 1'b0) begin
            miscompares++; $display("FAIL midreset_restart: got req %b addr %h valid %b expected 1 0000 0", bus.imem_req, bus.imem_addr, bus.id_valid);
        end
        @(negedge clk);
        vectors++;
        if (bus.id_valid !== 1'b0) begin
            miscompares++; $display("FAIL midreset_stale: got valid %b instr %h expected 0", bus.id_valid, bus.id_instruction);
        end
        @(negedge clk);
        vectors++;
        if (bus.id_valid !== 1'b1 || bus.id_instruction !== 16'h1000) begin
            miscompares++; $display("FAIL midreset_first: got valid %b instr %h expected 1 1000", bus.id_valid, bus.id_instruction);
        end
        repeat (4) @(negedge clk);
    endtask

    initial begin
        pc_reset          = 1'b1;
        bus.redirect      = 1'b0;
        bus.redirect_addr = 16'h0;
        bus.id_ready      = 1'b1;
        fork
            monitor();
        join_none
        test_reset();
        test_back_to_back();
        test_stall();
        test_redirect();
        test_redirect_full();
        test_wrap();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
